// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port unified memory of the multicycle MIPS core.
// Optional round-robin contention: define MEM_ARB_ROUND_ROBIN_EN (default fixed priority, port 0 wins).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       owner, owner_nxt;
    logic       last_winner, last_winner_nxt;
    logic       any_req;
    logic       winner;

    // Pick the port to serve when in IDLE (0 = port 0, 1 = port 1).
    always_comb begin
        any_req = m0_req | m1_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
            winner = ~last_winner;
        end else begin
            winner = m1_req;
        end
`else
        winner = m1_req & ~m0_req;
`endif
    end

    // Next-state logic and all port/memory outputs; outputs forced low while in reset.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        owner_nxt       = owner;
        last_winner_nxt = last_winner;
        m0_gnt          = 1'b0;
        m1_gnt          = 1'b0;
        m0_rvalid       = 1'b0;
        m1_rvalid       = 1'b0;
        m0_rdata        = '0;
        m1_rdata        = '0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        busy            = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    m0_gnt          = ~winner;
                    m1_gnt          = winner;
                    mem_en          = 1'b1;
                    mem_we          = winner ? m1_we : m0_we;
                    mem_addr        = winner ? m1_addr : m0_addr;
                    mem_wdata       = winner ? m1_wdata : m0_wdata;
                    last_winner_nxt = winner;
                    if (!mem_we) begin
                        owner_nxt = winner;
                        cnt_nxt   = LAT_M1;
                        state_nxt = (RD_LAT == 1) ? RD_DONE : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                if (owner) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = mem_rdata;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = mem_rdata;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!rstb) begin
            m0_gnt    = 1'b0;
            m1_gnt    = 1'b0;
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
            m0_rdata  = '0;
            m1_rdata  = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            busy      = 1'b0;
        end
    end

    // State, latency counter, read owner and last grant winner.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            owner       <= 1'b0;
            last_winner <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            owner       <= owner_nxt;
            last_winner <= last_winner_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard for read data,
// hand sequences for read latency, contention, mid-read reset and an RD_LAT=1 instance.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstb;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_m1_req;
    logic [31:0] b_m1_addr;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] zero32;

    int nvec;
    int nerr;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  rd_idx;
    logic [3:0]  rd_cnt;
    logic [3:0]  b_rd_cnt;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, en, we;
        logic [31:0] ea, ed;
    } vec_t;

    vec_t tbl [6];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut (
        .clk(clk), .rstb(rstb),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rstb(rstb),
        .m0_req(1'b0), .m0_we(1'b0), .m0_addr(zero32), .m0_wdata(zero32),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr(b_m1_addr), .m1_wdata(zero32),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data appears exactly RD_LAT cycles after the issuing mem_en cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            rd_idx <= mem_addr[9:2];
            rd_cnt <= 4'd1;
        end else if (rd_cnt != 4'd0 && rd_cnt != 4'd15) begin
            rd_cnt <= rd_cnt + 4'd1;
        end
        if (b_mem_en && !b_mem_we) begin
            b_rd_cnt <= 4'd1;
        end else if (b_rd_cnt != 4'd0 && b_rd_cnt != 4'd15) begin
            b_rd_cnt <= b_rd_cnt + 4'd1;
        end
    end

    assign mem_rdata   = (rd_cnt == 4'd2) ? mem[rd_idx] : 32'hBAD0_BAD0;
    assign b_mem_rdata = (b_rd_cnt == 4'd1) ? 32'hCAFE_F00D : 32'hBAD1_BAD1;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    task automatic samp();
        @(negedge clk);
        if (m0_rvalid) begin
            if (q0.size() == 0) begin
                chk("m0_rvalid_unexpected", m0_rvalid, 0);
            end else begin
                chk("m0_rdata", m0_rdata, q0.pop_front());
            end
            chk("m1_rdata_nonowner", {m1_rvalid, m1_rdata}, 0);
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) begin
                chk("m1_rvalid_unexpected", m1_rvalid, 0);
            end else begin
                chk("m1_rdata", m1_rdata, q1.pop_front());
            end
            chk("m0_rdata_nonowner", {m0_rvalid, m0_rdata}, 0);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            nxt();
            samp();
        end
        chk("drain_timeout", q0.size() + q1.size(), 0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        zero32 = 0;
        b_m1_req = 0;
        b_m1_addr = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        rd_cnt = 0;
        b_rd_cnt = 0;
        rd_idx = 0;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 'h40, 'h1111, 0, 0, 0, 0, 1, 0, 1, 1, 'h40, 'h1111};
        tbl[2] = '{0, 0, 0, 0, 1, 1, 'h20, 'h1234, 0, 1, 1, 1, 'h20, 'h1234};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 'h24, 'h5678, 0, 1, 1, 1, 'h24, 'h5678};
        tbl[4] = '{1, 1, 'h44, 'hAAAA, 1, 1, 'h48, 'hBBBB, 1, 0, 1, 1, 'h44, 'hAAAA};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tbl[5] = '{1, 1, 'h44, 'hA5A5, 1, 1, 'h48, 'hB5B5, 0, 1, 1, 1, 'h48, 'hB5B5};
`else
        tbl[5] = '{1, 1, 'h44, 'hA5A5, 1, 1, 'h48, 'hB5B5, 1, 0, 1, 1, 'h44, 'hA5A5};
`endif

        // Reset with a request pending: everything must read 0.
        rstb = 0;
        idle_in();
        m0_req = 1; m0_we = 1; m0_addr = 'h40; m0_wdata = 'h99;
        samp();
        chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rst_mem", {mem_en, mem_we, busy}, 0);
        chk("rst_addr", {mem_addr, mem_wdata}, 0);
        nxt();
        rstb = 1;
        idle_in();

        // Vector table: single-cycle write/idle behaviour.
        for (int i = 0; i < 6; i++) begin
            m0_req = tbl[i].r0; m0_we = tbl[i].w0;
            m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
            m1_req = tbl[i].r1; m1_we = tbl[i].w1;
            m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
            samp();
            chk($sformatf("vec%0d_gnt", i), {m0_gnt, m1_gnt}, {tbl[i].g0, tbl[i].g1});
            chk($sformatf("vec%0d_en_we", i), {mem_en, mem_we, busy}, {tbl[i].en, tbl[i].we, 1'b0});
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].ea);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].ed);
            if (tbl[i].en && tbl[i].we) ref_mem[tbl[i].ea[9:2]] = tbl[i].ed;
            nxt();
        end
        idle_in();
        samp();
        chk("mem_0x20", mem[8], 32'h1234);
        chk("mem_0x24", mem[9], 32'h5678);
        nxt();

        // Sustained write contention for four grants.
        m0_req = 1; m0_we = 1; m0_addr = 'h60; m0_wdata = 'h60;
        m1_req = 1; m1_we = 1; m1_addr = 'h64; m1_wdata = 'h64;
        for (int i = 0; i < 4; i++) begin
            logic exp1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            samp();
            chk($sformatf("cont%0d_gnt", i), {m0_gnt, m1_gnt}, {~exp1, exp1});
            nxt();
        end
        idle_in();

        // Port 0 read at 0x10; port 1 read raised one cycle later must wait.
        m0_req = 1; m0_we = 0; m0_addr = 'h10;
        samp();
        chk("rd_T_gnt", {m0_gnt, m1_gnt, mem_en, mem_we, busy}, 5'b10100);
        chk("rd_T_addr", mem_addr, 'h10);
        q0.push_back(ref_mem[4]);
        nxt();
        idle_in();
        m1_req = 1; m1_we = 0; m1_addr = 'h20;
        samp();
        chk("rd_T1", {m1_gnt, mem_en, busy}, 3'b001);
        nxt();
        samp();
        chk("rd_T2", {m1_gnt, mem_en, busy, m0_rvalid}, 4'b0011);
        nxt();
        samp();
        chk("rd_T3_gnt", {m1_gnt, m0_gnt, mem_en, busy}, 4'b1010);
        q1.push_back(ref_mem[8]);
        nxt();
        idle_in();
        samp();
        drain();

        // Reset while a read is in flight: no rvalid for it, ever.
        nxt();
        m0_req = 1; m0_we = 0; m0_addr = 'h10;
        samp();
        chk("rr_gnt", m0_gnt, 1);
        nxt();
        idle_in();
        rstb = 0;
        samp();
        chk("rr_during", {busy, m0_rvalid}, 0);
        nxt();
        rstb = 1;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk($sformatf("rr_after%0d", i), {busy, m0_rvalid, m1_rvalid}, 0);
            nxt();
        end

        // Contention right after reset goes to port 0 in both builds.
        m0_req = 1; m0_we = 1; m0_addr = 'h70; m0_wdata = 'h70;
        m1_req = 1; m1_we = 1; m1_addr = 'h74; m1_wdata = 'h74;
        samp();
        chk("post_rst_cont", {m0_gnt, m1_gnt}, 2'b10);
        nxt();
        idle_in();

        // Fresh read after reset returns the right data.
        m0_req = 1; m0_we = 0; m0_addr = 'h20;
        samp();
        chk("fresh_gnt", m0_gnt, 1);
        q0.push_back(ref_mem[8]);
        nxt();
        idle_in();
        samp();
        drain();

        // RD_LAT=1 instance: rvalid at T+1, next grant at T+2.
        nxt();
        b_m1_req = 1; b_m1_addr = 'h30;
        samp();
        chk("lat1_T_gnt", {b_m1_gnt, b_mem_en, b_busy}, 3'b110);
        nxt();
        samp();
        chk("lat1_T1", {b_m1_gnt, b_m1_rvalid, b_m0_rvalid, b_busy}, 4'b0101);
        chk("lat1_rdata", b_m1_rdata, 32'hCAFE_F00D);
        nxt();
        samp();
        chk("lat1_T2_gnt", b_m1_gnt, 1);
        nxt();
        b_m1_req = 0;
        samp();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle MIPS core between two requesters.
- Port 0 is the CPU memory interface, driven by the control FSM through i_or_d, mem_write and ir_write.
- Port 1 is the program-loader/debug interface.
- Only one transaction is outstanding at a time. A requester is granted, holds the memory for a write (1 cycle) or a read (RD_LAT+1 cycles), and receives a read-data valid pulse.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- RD_LAT, 2, memory read latency in cycles, from the mem_en cycle to mem_rdata valid. Legal range 1..15.

Ports:
- clk  input  1  clock
- rstb  input  1  synchronous active-low reset
- m0_req  input  1  port 0 request; held high until m0_gnt
- m0_we  input  1  port 0 write enable (1 = write, 0 = read)
- m0_addr  input  ADDR_W  port 0 address
- m0_wdata  input  DATA_W  port 0 write data
- m0_gnt  output  1  port 0 grant, 1-cycle pulse
- m0_rvalid  output  1  port 0 read data valid, 1-cycle pulse
- m0_rdata  output  DATA_W  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: rstb is synchronous, active-low; clock clk. While rstb=0 at a rising edge:
  - state <= IDLE, latency counter <= 0, owner <= 0, last_winner <= 1.
  - All outputs read 0 during reset: gnt, rvalid, mem_en, mem_we, busy; addr/wdata/rdata also 0.
- States:
  - IDLE: no transaction.
  - RD_WAIT: read issued, counting latency.
  - RD_DONE: read data returned this cycle.
- IDLE:
  - Grant is combinational from req. The winner's gnt=1 and mem_en=1 in the same cycle.
  - mem_we, mem_addr and mem_wdata are muxed from the winner.
  - With no request, mem_en=0 and mem_addr/mem_wdata are driven 0.
  - Write granted: the write completes in that cycle and state stays IDLE. Back-to-back writes from the same or the other port are allowed every cycle.
  - Read granted: owner <= winner, counter <= RD_LAT-1, state <= RD_WAIT. If RD_LAT=1, state goes directly to RD_DONE.
- RD_WAIT:
  - No grants. mem_en=0.
  - counter decrements each cycle; at counter==1, state <= RD_DONE.
- RD_DONE (exactly RD_LAT cycles after the mem_en cycle):
  - The owner's rvalid=1 and its rdata=mem_rdata combinationally.
  - The non-owner's rvalid=0 and its rdata=0.
  - No grant this cycle. state <= IDLE.
- Read occupancy is RD_LAT+1 cycles. The next grant is available the cycle after RD_DONE.
- Arbitration, single request: the requester is granted immediately.
- Arbitration, both requesting in IDLE: decided per the Optional Feature. last_winner updates on every grant.
- Requesters must hold req, we, addr and wdata stable until gnt. A req dropped before gnt is legal and simply not served.
- Requests arriving during RD_WAIT/RD_DONE wait; no gnt is issued.
- Reset mid-read: the transaction is abandoned. No rvalid is ever issued for it; the first cycle after reset release is IDLE.
- busy=1 in RD_WAIT and RD_DONE; 0 in IDLE, including on write-grant cycles.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port that is not last_winner is granted, so alternate grants occur under sustained contention. Port 0 wins the first contention after reset.
- Undefined: fixed priority; port 0 always wins contention. last_winner is still maintained but unused.

Test Plan:
- Port 0 read at addr 0x10, memory model returns 0xDEADBEEF, RD_LAT=2 -> m0_gnt+mem_en at cycle T, busy at T+1..T+2, m0_rvalid with m0_rdata=0xDEADBEEF at T+2, m1_rvalid=0 throughout.
- Port 1 writes 0x1234 to addr 0x20 and 0x5678 to addr 0x24 in consecutive cycles -> mem_en=mem_we=1 on both cycles, busy=0, memory holds both values.
- Both ports hold write requests continuously for 4 grants -> round-robin build: grants alternate 0,1,0,1. Fixed build: port 0 granted 4 times, port 1 never.
- Port 0 read in flight, port 1 raises req at T+1 -> m1_gnt first asserted at T+RD_LAT+1, not earlier.
- rstb=0 at T+1 during a port 0 read -> no m0_rvalid ever; busy=0 after reset. A fresh read after release returns correct data.
- RD_LAT=1 build, port 1 read of 0xCAFEF00D -> m1_rvalid at T+1, next grant possible at T+2.
